// File: rtl/memory_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_datapath_if
//  Description : Bus bundle between the memory controller and the memory
//                datapath. The controller (master) supplies the state flag,
//                enables and write data; the datapath (slave) returns read
//                data, the read strobe, the active pointer and status flags.
//  Signals     : PresentStateFlag[1:0], MemoryEnable, WriteEnable,
//                DataIn[DATA_W-1:0]        -> controller to datapath
//                DataOut[DATA_W-1:0], ReadValid, Address[ADDR_W-1:0],
//                Full, Empty, Overflow     -> datapath to controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic [1:0]        PresentStateFlag;
    logic              MemoryEnable;
    logic              WriteEnable;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              ReadValid;
    logic [ADDR_W-1:0] Address;
    logic              Full;
    logic              Empty;
    logic              Overflow;

    modport master (
        output PresentStateFlag, MemoryEnable, WriteEnable, DataIn,
        input  DataOut, ReadValid, Address, Full, Empty, Overflow
    );

    modport slave (
        input  PresentStateFlag, MemoryEnable, WriteEnable, DataIn,
        output DataOut, ReadValid, Address, Full, Empty, Overflow
    );
endinterface
`default_nettype wire

// File: rtl/memory_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : memory_datapath
//  Description : 2^ADDR_W x DATA_W FIFO-style memory datapath steered by an
//                external controller state flag (0 Idle, 1 Write, 2 Read,
//                3 invalid). Writes fire on the rising edge of WriteEnable,
//                reads drain one word per cycle while in Read.
//  Ports       : clock1Hz - system clock, rising edge
//                reset    - asynchronous active-low reset
//                bus      - memory_datapath_if.slave (flag, enables, data,
//                           status, active address)
//  Options     : OVERFLOW_FLAG_EN - when defined, a sticky Overflow flag is
//                set by any write strobe that arrives while full; otherwise
//                Overflow is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic          clock1Hz,
    input  wire logic          reset,
    memory_datapath_if.slave   bus
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [1:0]        ST_WRITE   = 2'd1;
    localparam logic [1:0]        ST_READ    = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              we_q;
    logic [DATA_W-1:0] data_out_q;
    logic              read_valid_q;

    logic              full;
    logic              empty;
    logic              write_strobe;
    logic              write_fire;
    logic              read_fire;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Edge detect so a level-held WriteEnable produces a single write.
    assign write_strobe = bus.WriteEnable & ~we_q;
    assign write_fire   = write_strobe & (bus.PresentStateFlag == ST_WRITE)
                        & bus.MemoryEnable & ~full;
    // Read and write are qualified by different state codes, so they can
    // never fire together and count never sees a simultaneous +1/-1.
    assign read_fire    = (bus.PresentStateFlag == ST_READ)
                        & bus.MemoryEnable & ~empty;

    always_ff @(posedge clock1Hz or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            we_q         <= bus.WriteEnable;
            read_valid_q <= read_fire;
            if (write_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end else if (read_fire) begin
                data_out_q <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + CNT_ONE[ADDR_W-1:0];
                count      <= count - CNT_ONE;
            end
        end
    end

    // Storage has no reset; reset level still blocks writes so an access in
    // flight when reset drops is aborted.
    always_ff @(posedge clock1Hz) begin
        if (reset && write_fire) begin
            mem[wr_ptr] <= bus.DataIn;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clock1Hz or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (write_strobe && (bus.PresentStateFlag == ST_WRITE)
                     && bus.MemoryEnable && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.Overflow = overflow_q;
`else
    assign bus.Overflow = 1'b0;
`endif

    assign bus.DataOut   = data_out_q;
    assign bus.ReadValid = read_valid_q;
    assign bus.Full      = full;
    assign bus.Empty     = empty;
    assign bus.Address   = (bus.PresentStateFlag == ST_READ) ? rd_ptr : wr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_memory_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_datapath
//  Description : Self-checking bench for memory_datapath: a directed vector
//                table, hand-written sequences for full/overflow, pointer
//                wrap and mid-operation reset, and a randomized run checked
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk;
    logic reset;

    memory_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock1Hz (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];
    int                wr_total;
    int                rd_total;
    bit                prev_we;
    logic [DATA_W-1:0] m_dout;
    bit                m_rv;
    bit                m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wr_total = 0;
        rd_total = 0;
        prev_we  = 1'b0;
        m_dout   = '0;
        m_rv     = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] flag, input bit me, input bit we,
                              input logic [DATA_W-1:0] din);
        bit strobe;
        strobe = we && !prev_we;
        m_rv   = 1'b0;
        if (strobe && flag == 2'd1 && me) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(din);
                wr_total++;
            end else begin
`ifdef OVERFLOW_FLAG_EN
                m_ovf = 1'b1;
`endif
            end
        end
        if (flag == 2'd2 && me && mq.size() > 0) begin
            m_dout = mq.pop_front();
            m_rv   = 1'b1;
            rd_total++;
        end
        prev_we = we;
    endtask

    task automatic model_check(input string tag);
        int exp_addr;
        exp_addr = (bus.PresentStateFlag == 2'd2) ? (rd_total % DEPTH) : (wr_total % DEPTH);
        check({tag, ".dout"},  32'(bus.DataOut),   32'(m_dout));
        check({tag, ".rv"},    32'(bus.ReadValid), 32'(m_rv));
        check({tag, ".full"},  32'(bus.Full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.Empty),     32'(mq.size() == 0));
        check({tag, ".addr"},  32'(bus.Address),   32'(exp_addr));
        check({tag, ".ovf"},   32'(bus.Overflow),  32'(m_ovf));
    endtask

    // Called at a negedge: drive, clock, compare, return at the next negedge.
    task automatic cycle(input logic [1:0] flag, input bit me, input bit we,
                         input logic [DATA_W-1:0] din, input string tag);
        bus.PresentStateFlag = flag;
        bus.MemoryEnable     = me;
        bus.WriteEnable      = we;
        bus.DataIn           = din;
        @(posedge clk);
        model_step(flag, me, we, din);
        #1;
        model_check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.PresentStateFlag = 2'd0;
        bus.MemoryEnable     = 1'b0;
        bus.WriteEnable      = 1'b0;
        bus.DataIn           = '0;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst.dout",  32'(bus.DataOut),   32'h0);
        check("rst.rv",    32'(bus.ReadValid), 32'h0);
        check("rst.empty", 32'(bus.Empty),     32'h1);
        check("rst.full",  32'(bus.Full),      32'h0);
        check("rst.addr",  32'(bus.Address),   32'h0);
        check("rst.ovf",   32'(bus.Overflow),  32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]        flag;
        logic              me;
        logic              we;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
        logic              rv;
        logic              full;
        logic              empty;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // three write pulses (each held 3 cycles) then five read cycles
        tbl[0]  = '{2'd1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[1]  = '{2'd1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[2]  = '{2'd1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[3]  = '{2'd1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[4]  = '{2'd1, 1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[5]  = '{2'd1, 1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[6]  = '{2'd1, 1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[7]  = '{2'd1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[8]  = '{2'd1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[9]  = '{2'd1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[10] = '{2'd1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[11] = '{2'd1, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[12] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[13] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h22, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[14] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1, 4'd3};
        tbl[15] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b1, 4'd3};
        tbl[16] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b1, 4'd3};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DATA_W-1:0] exp_vals[$];

        reset = 1'b0;
        bus.PresentStateFlag = 2'd0;
        bus.MemoryEnable     = 1'b0;
        bus.WriteEnable      = 1'b0;
        bus.DataIn           = '0;
        model_reset();

        do_reset();

        // table-driven basic write/read
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].flag, tbl[i].me, tbl[i].we, tbl[i].din, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.dout", i),  32'(bus.DataOut),   32'(tbl[i].dout));
            check($sformatf("tbl%0d.rv", i),    32'(bus.ReadValid), 32'(tbl[i].rv));
            check($sformatf("tbl%0d.full", i),  32'(bus.Full),      32'(tbl[i].full));
            check($sformatf("tbl%0d.empty", i), 32'(bus.Empty),     32'(tbl[i].empty));
            check($sformatf("tbl%0d.addr", i),  32'(bus.Address),   32'(tbl[i].addr));
        end

        // full / overflow: 17 strobes, the last one must be dropped
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(2'd1, 1'b1, 1'b1, 8'(i), "fill");
            if (i == 15) check("fill.full16", 32'(bus.Full), 32'h1);
            cycle(2'd1, 1'b1, 1'b0, 8'(i), "fill");
        end
        check("fill.full17", 32'(bus.Full), 32'h1);
        check("fill.addr17", 32'(bus.Address), 32'h0);
`ifdef OVERFLOW_FLAG_EN
        check("fill.ovf", 32'(bus.Overflow), 32'h1);
`else
        check("fill.ovf", 32'(bus.Overflow), 32'h0);
`endif
        for (int i = 0; i < 16; i++) begin
            cycle(2'd2, 1'b1, 1'b0, 8'h00, "drain");
            check($sformatf("drain%0d.data", i), 32'(bus.DataOut), 32'(i));
            check($sformatf("drain%0d.rv", i),   32'(bus.ReadValid), 32'h1);
        end
        cycle(2'd2, 1'b1, 1'b0, 8'h00, "drain");
        check("drain.rv_after", 32'(bus.ReadValid), 32'h0);
        check("drain.hold",     32'(bus.DataOut),   32'h0f);
        check("drain.empty",    32'(bus.Empty),     32'h1);

        // pointer wrap: write 10, read 10, write 10, read 10
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(2'd1, 1'b1, 1'b1, 8'hA0 + 8'(i), "wrapw1");
            cycle(2'd1, 1'b1, 1'b0, 8'h00, "wrapw1");
        end
        for (int i = 0; i < 10; i++) cycle(2'd2, 1'b1, 1'b0, 8'h00, "wrapr1");
        for (int i = 0; i < 10; i++) begin
            exp_vals.push_back(8'h50 + 8'(i * 3));
            cycle(2'd1, 1'b1, 1'b1, 8'h50 + 8'(i * 3), "wrapw2");
            cycle(2'd1, 1'b1, 1'b0, 8'h00, "wrapw2");
        end
        for (int i = 0; i < 10; i++) begin
            cycle(2'd2, 1'b1, 1'b0, 8'h00, "wrapr2");
            check($sformatf("wrap%0d.data", i), 32'(bus.DataOut), 32'(exp_vals[i]));
        end
        check("wrap.rd_ptr", 32'(bus.Address), 32'h4);
        cycle(2'd0, 1'b1, 1'b0, 8'h00, "wrapidle");
        check("wrap.wr_ptr", 32'(bus.Address), 32'h4);

        // reset mid-write with WriteEnable held high
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2'd1, 1'b1, 1'b1, 8'h70 + 8'(i), "prew");
            cycle(2'd1, 1'b1, 1'b0, 8'h00, "prew");
        end
        check("prew.addr", 32'(bus.Address), 32'h5);
        bus.WriteEnable = 1'b1;
        bus.DataIn      = 8'hEE;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst.empty", 32'(bus.Empty),   32'h1);
        check("midrst.addr",  32'(bus.Address), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(2'd1, 1'b1, 1'b1, 8'hEE, "postrst");
        check("postrst.empty", 32'(bus.Empty),   32'h0);
        check("postrst.addr",  32'(bus.Address), 32'h1);
        cycle(2'd1, 1'b1, 1'b1, 8'hEF, "postrst");
        check("postrst.once",  32'(bus.Address), 32'h1);
        cycle(2'd2, 1'b1, 1'b0, 8'h00, "postrst");
        check("postrst.data",  32'(bus.DataOut), 32'hEE);

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [1:0] f;
            bit         me;
            bit         we;
            f  = 2'($urandom_range(0, 3));
            me = ($urandom_range(0, 7) != 0);
            we = 1'($urandom_range(0, 1));
            cycle(f, me, we, 8'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
